// File: rtl/master_spi_adapter.sv
// SPI mode-0 master exchanging fixed 32-bit {id[3:0], data[27:0]} frames, MSB first, full duplex.
// Define MASTER_SPI_CHECK_EN to compare each response against an expected frame and count failures.
module master_spi_adapter #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  tx_id,
    input  logic [27:0] tx_data,
    input  logic        exp_en,
    input  logic [3:0]  exp_id,
    input  logic [27:0] exp_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  rx_id,
    output logic [27:0] rx_data,
    output logic        mismatch,
    output logic [7:0]  err_count,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_HALF = 6'd63;

    state_t      state;
    state_t      state_next;
    logic [7:0]  div_cnt;
    logic [5:0]  half_cnt;
    logic        sclk_q;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [3:0]  rx_id_q;
    logic [27:0] rx_data_q;
    logic        done_q;
    logic        tick;
    logic        accept;
    logic        rise_evt;
    logic        fall_evt;
    logic        frame_end;

    // Every timed state lasts a whole number of CLK_DIV periods; tick marks the last cycle of one.
    assign tick      = (div_cnt == DIV_LAST);
    assign accept    = (state == IDLE) && start;
    assign rise_evt  = tick && ((state == SETUP) ||
                                (state == SHIFT && !sclk_q && half_cnt != LAST_HALF));
    assign fall_evt  = tick && (state == SHIFT) && sclk_q;
    assign frame_end = tick && (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick) state_next = SHIFT;
            SHIFT:   if (tick && half_cnt == LAST_HALF) state_next = HOLD;
            HOLD:    if (tick) state_next = GAP;
            GAP:     if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        spi_cs   = (state == IDLE) || (state == GAP);
        spi_mosi = (state == IDLE) ? 1'b0 : tx_sr[31];
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // The final half-period after the 32nd fall keeps SCLK low before HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            half_cnt <= '0;
            sclk_q   <= 1'b0;
        end else if (state == SETUP) begin
            half_cnt <= '0;
            sclk_q   <= tick;
        end else if (state == SHIFT && tick) begin
            half_cnt <= half_cnt + 6'd1;
            sclk_q   <= (half_cnt != LAST_HALF) && !sclk_q;
        end else if (state != SHIFT) begin
            sclk_q   <= 1'b0;
        end
    end

    // MOSI shifts out zeros behind the frame, so it returns to 0 after the 32nd falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr <= '0;
        end else if (accept) begin
            tx_sr <= {tx_id, tx_data};
        end else if (fall_evt) begin
            tx_sr <= {tx_sr[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr <= '0;
        end else if (rise_evt) begin
            rx_sr <= {rx_sr[30:0], spi_miso};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_id_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (frame_end) begin
                rx_id_q   <= rx_sr[31:28];
                rx_data_q <= rx_sr[27:0];
            end
        end
    end

    assign done    = done_q;
    assign rx_id   = rx_id_q;
    assign rx_data = rx_data_q;
    assign spi_clk = sclk_q;

`ifdef MASTER_SPI_CHECK_EN
    logic        exp_en_q;
    logic [31:0] exp_word_q;
    logic        mismatch_q;
    logic [7:0]  err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_en_q   <= 1'b0;
            exp_word_q <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            mismatch_q <= 1'b0;
            if (accept) begin
                exp_en_q   <= exp_en;
                exp_word_q <= {exp_id, exp_data};
            end
            if (frame_end && exp_en_q && rx_sr != exp_word_q) begin
                mismatch_q <= 1'b1;
                if (err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
            end
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_q;
`else
    // Expectation inputs have no function in this build.
    logic unused_exp;
    assign unused_exp = ^{exp_en, exp_id, exp_data};
    assign mismatch   = 1'b0;
    assign err_count  = 8'd0;
`endif

endmodule

// File: tb/tb_master_spi_adapter.sv
// Scoreboard bench for master_spi_adapter: a CLK_DIV=4 instance for frame behaviour and
// a CLK_DIV=1 instance for back-to-back timing and error-count saturation.
module tb_master_spi_adapter;

`ifdef MASTER_SPI_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] reply;
        logic [31:0] mosi;
        logic        mis;
        logic [7:0]  err;
    } exp_t;

    logic clk;
    logic rst;

    logic        start, exp_en, busy, done, mismatch, spi_clk, spi_mosi, spi_miso, spi_cs;
    logic [3:0]  tx_id, exp_id, rx_id;
    logic [27:0] tx_data, exp_data, rx_data;
    logic [7:0]  err_count;

    logic        f_start, f_exp_en, f_busy, f_done, f_mismatch, f_spi_clk, f_spi_mosi, f_spi_miso, f_spi_cs;
    logic [3:0]  f_tx_id, f_exp_id, f_rx_id;
    logic [27:0] f_tx_data, f_exp_data, f_rx_data;
    logic [7:0]  f_err_count;

    int checkCount = 0;
    int errorCount = 0;
    int done_seen = 0;
    int f_done_seen = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] model_err = 8'd0;

    master_spi_adapter #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .tx_id(tx_id), .tx_data(tx_data),
        .exp_en(exp_en), .exp_id(exp_id), .exp_data(exp_data), .busy(busy), .done(done),
        .rx_id(rx_id), .rx_data(rx_data), .mismatch(mismatch), .err_count(err_count),
        .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
    );

    master_spi_adapter #(.CLK_DIV(1)) dut_fast (
        .clk(clk), .rst(rst), .start(f_start), .tx_id(f_tx_id), .tx_data(f_tx_data),
        .exp_en(f_exp_en), .exp_id(f_exp_id), .exp_data(f_exp_data), .busy(f_busy), .done(f_done),
        .rx_id(f_rx_id), .rx_data(f_rx_data), .mismatch(f_mismatch), .err_count(f_err_count),
        .spi_clk(f_spi_clk), .spi_mosi(f_spi_mosi), .spi_miso(f_spi_miso), .spi_cs(f_spi_cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: reply word latched at CS fall, shifted on SCLK falls; MOSI captured on rises.
    logic [31:0] slave_reply = 32'd0;
    logic [31:0] slv_word = 32'd0;
    logic [31:0] mosi_cap = 32'd0;
    int falls = 0, falls_base = 0, slv_idx, rise_count = 0;

    always @(negedge spi_clk) falls <= falls + 1;
    always @(negedge spi_cs) begin
        slv_word   = slave_reply;
        falls_base = falls;
    end
    always @(posedge spi_clk) begin
        mosi_cap   <= {mosi_cap[30:0], spi_mosi};
        rise_count <= rise_count + 1;
    end
    assign slv_idx  = falls - falls_base;
    assign spi_miso = (slv_idx >= 0 && slv_idx < 32) ? slv_word[31 - slv_idx] : 1'b0;

    logic [31:0] f_reply = 32'h5A3C_96E1;
    logic [31:0] f_slv_word = 32'd0;
    logic [31:0] f_mosi_cap = 32'd0;
    int f_falls = 0, f_falls_base = 0, f_slv_idx;

    always @(negedge f_spi_clk) f_falls <= f_falls + 1;
    always @(negedge f_spi_cs) begin
        f_slv_word   = f_reply;
        f_falls_base = f_falls;
    end
    always @(posedge f_spi_clk) f_mosi_cap <= {f_mosi_cap[30:0], f_spi_mosi};
    assign f_slv_idx  = f_falls - f_falls_base;
    assign f_spi_miso = (f_slv_idx >= 0 && f_slv_idx < 32) ? f_slv_word[31 - f_slv_idx] : 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checkCount++;
        if (got !== expv) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest pushed frame.
    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("rx_id", {28'd0, rx_id}, {28'd0, mon_e.reply[31:28]});
                checkOutput("rx_data", {4'd0, rx_data}, {4'd0, mon_e.reply[27:0]});
                checkOutput("mosi_word", mosi_cap, mon_e.mosi);
                checkOutput("mismatch", {31'd0, mismatch}, {31'd0, mon_e.mis});
                checkOutput("err_count", {24'd0, err_count}, {24'd0, mon_e.err});
            end
        end
        if (f_done) f_done_seen++;
    end

    task automatic applyStimulus(input logic [3:0] id, input logic [27:0] data, input logic en,
                                 input logic [3:0] eid, input logic [27:0] edata,
                                 input logic [31:0] reply);
        exp_t e;
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        checkOutput("idle_before_start", {31'd0, busy}, 32'd0);
        slave_reply = reply;
        e.reply = reply;
        e.mosi  = {id, data};
        e.mis   = CHECK_EN && en && (reply != {eid, edata});
        if (e.mis && model_err != 8'hFF) model_err = model_err + 8'd1;
        e.err   = CHECK_EN ? model_err : 8'd0;
        sb.push_back(e);
        tx_id = id; tx_data = data; exp_en = en; exp_id = eid; exp_data = edata;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, rise_at, done_at, busy_len, base, n;
        int runs[2];
        int nruns, run, idle, csgap, ndone;
        logic prev_busy;

        rst = 1'b1;
        start = 1'b0; tx_id = '0; tx_data = '0; exp_en = 1'b0; exp_id = '0; exp_data = '0;
        f_start = 1'b0; f_tx_id = '0; f_tx_data = '0; f_exp_en = 1'b0; f_exp_id = '0; f_exp_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cs", {31'd0, spi_cs}, 32'd1);
        checkOutput("rst_sclk", {31'd0, spi_clk}, 32'd0);
        checkOutput("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_mismatch", {31'd0, mismatch}, 32'd0);
        checkOutput("rst_rx", {rx_id, rx_data}, 32'd0);
        checkOutput("rst_err", {24'd0, err_count}, 32'd0);
        checkOutput("rst_fast_cs", {31'd0, f_spi_cs}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic send/receive");
        applyStimulus(4'd14, 28'd1, 1'b1, 4'd0, 28'h1000000, 32'h0100_0000);
        checkOutput("cs_latency", {31'd0, spi_cs}, 32'd0);
        checkOutput("mosi_first_bit", {31'd0, spi_mosi}, 32'd1);
        cyc = 0; rise_at = -1; done_at = -1; busy_len = busy ? 1 : 0;
        while (cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (spi_clk && rise_at < 0) rise_at = cyc;
            if (done && done_at < 0) done_at = cyc;
            if (busy) busy_len++;
            else break;
        end
        checkOutput("first_rise", rise_at, 32'd4);
        checkOutput("done_latency", done_at, 32'd264);
        checkOutput("busy_len", busy_len, 32'd268);
        repeat (5) @(negedge clk);
        checkOutput("rx_hold", {rx_id, rx_data}, 32'h0100_0000);
        checkOutput("idle_mosi", {31'd0, spi_mosi}, 32'd0);

        $display("[TB] mismatch path");
        applyStimulus(4'd3, 28'h0ABCDEF, 1'b1, 4'd0, 28'hB000000, 32'h0100_0001);
        waitDone();
        applyStimulus(4'd7, 28'h1234567, 1'b1, 4'd0, 28'h1000001, 32'h0100_0001);
        waitDone();
        @(negedge clk);
        checkOutput("err_after_match", {24'd0, err_count}, CHECK_EN ? 32'd1 : 32'd0);

        $display("[TB] busy rejection");
        base = done_seen;
        applyStimulus(4'd5, 28'h0F0F0F0, 1'b0, 4'd0, 28'd0, 32'hC3A5_5A3C);
        @(negedge clk);
        tx_id = 4'd9; tx_data = 28'hFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        repeat (300) @(negedge clk);
        checkOutput("busy_reject_dones", done_seen - base, 32'd1);
        checkOutput("busy_reject_idle", {31'd0, busy}, 32'd0);

        $display("[TB] reset mid-frame");
        base = rise_count;
        applyStimulus(4'd2, 28'h7654321, 1'b0, 4'd0, 28'd0, 32'h1111_2222);
        for (int i = 0; i < 2000 && (rise_count - base) < 10; i++) @(negedge clk);
        checkOutput("rises_before_reset", rise_count - base, 32'd10);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_cs", {31'd0, spi_cs}, 32'd1);
        checkOutput("abort_sclk", {31'd0, spi_clk}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_err", {24'd0, err_count}, 32'd0);
        checkOutput("abort_rx", {rx_id, rx_data}, 32'd0);
        sb.delete();
        model_err = 8'd0;
        rst = 1'b0;
        base = done_seen;
        repeat (300) @(negedge clk);
        checkOutput("abort_no_done", done_seen - base, 32'd0);
        applyStimulus(4'd11, 28'h0DEAD01, 1'b1, 4'd4, 28'h0000001, 32'h4000_0001);
        waitDone();

        $display("[TB] CLK_DIV=1 back-to-back");
        f_tx_id = 4'h9; f_tx_data = 28'h0123456; f_exp_en = 1'b0;
        f_start = 1'b1;
        nruns = 0; run = 0; idle = 0; csgap = 0; ndone = 0; prev_busy = 1'b0;
        runs[0] = 0; runs[1] = 0;
        for (int c = 0; c < 400 && nruns < 2; c++) begin
            @(negedge clk);
            if (f_done) ndone++;
            if (ndone == 1 && f_spi_cs) csgap++;
            if (f_busy) begin
                run++;
                if (nruns == 1) f_start = 1'b0;
            end else if (prev_busy) begin
                runs[nruns] = run;
                nruns++;
                run = 0;
            end
            if (nruns == 1 && !f_busy) idle++;
            prev_busy = f_busy;
        end
        f_start = 1'b0;
        checkOutput("b2b_busy_first", runs[0], 32'd67);
        checkOutput("b2b_busy_second", runs[1], 32'd67);
        checkOutput("b2b_idle_gap", idle, 32'd1);
        checkOutput("b2b_cs_gap_min", {31'd0, csgap >= 1}, 32'd1);
        checkOutput("b2b_dones", ndone, 32'd2);
        checkOutput("b2b_rx", {f_rx_id, f_rx_data}, 32'h5A3C_96E1);
        checkOutput("b2b_mosi", f_mosi_cap, 32'h9012_3456);

        $display("[TB] error counter saturation");
        f_exp_en = 1'b1; f_exp_id = 4'd0; f_exp_data = 28'd0;
        f_start = 1'b1;
        n = 0;
        for (int c = 0; c < 260 * 67 + 500; c++) begin
            @(negedge clk);
            if (f_done) begin
                n++;
                if (n == 1) begin
                    checkOutput("sat_err_1", {24'd0, f_err_count}, CHECK_EN ? 32'd1 : 32'd0);
                    checkOutput("sat_mis_1", {31'd0, f_mismatch}, {31'd0, CHECK_EN});
                end
                if (n == 255) checkOutput("sat_err_255", {24'd0, f_err_count}, CHECK_EN ? 32'd255 : 32'd0);
                if (n == 260) begin
                    f_start = 1'b0;
                    checkOutput("sat_mis_260", {31'd0, f_mismatch}, {31'd0, CHECK_EN});
                    break;
                end
            end
        end
        f_start = 1'b0;
        checkOutput("sat_frames", n, 32'd260);
        for (int i = 0; i < 200 && f_busy; i++) @(negedge clk);
        checkOutput("sat_err_final", {24'd0, f_err_count}, CHECK_EN ? 32'd255 : 32'd0);
        checkOutput("sat_idle", {31'd0, f_busy}, 32'd0);
        checkOutput("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
